// File: rtl/gray_checker.sv
// Gray-sequence checker: synchronises a Gray word, decodes it to binary and
// flags illegal transitions (multi-bit jumps or backward steps) while tracking.
module gray_checker #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic [WIDTH-1:0]     gray_in,
    output logic [WIDTH-1:0]     binary_out,
    output logic                 valid,
    output logic                 step,
    output logic                 wrap,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]     ONES_W   = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    state_t                           state;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                 prev;
    logic [WIDTH-1:0]                 dec;
    logic                             cmp_en;
    logic                             is_step;
    logic                             err_now;

    assign dec     = gray2bin(sync_q[SYNC_STAGES-1]);
    assign cmp_en  = (state == S_TRACK) && enable;
    // A +1 binary step always changes exactly one Gray bit, so anything else
    // that differs from prev is either a jump or a backward move.
    assign is_step = (dec == prev + WIDTH'(1));
    assign err_now = cmp_en && (dec != prev) && !is_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            binary_out <= '0;
            prev       <= '0;
            state      <= S_IDLE;
            valid      <= 1'b0;
            step       <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

            binary_out <= dec;
            step       <= 1'b0;
            wrap       <= 1'b0;
            err        <= err_now;

            case (state)
                S_IDLE: begin
                    valid <= 1'b0;
                    if (enable) state <= S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    prev  <= dec;
                    state <= S_TRACK;
                    valid <= 1'b1;
                end
                S_TRACK: begin
                    if (!enable) begin
                        state <= S_IDLE;
                        valid <= 1'b0;
                    end else begin
                        prev <= dec;
                        if (err_now) begin
                            state <= S_ERROR;
                            valid <= 1'b0;
                        end else begin
                            valid <= 1'b1;
                            if (is_step) begin
                                step <= 1'b1;
                                wrap <= (prev == ONES_W);
                            end
                        end
                    end
                end
                S_ERROR: begin
                    valid <= 1'b0;
                    state <= enable ? S_ACQUIRE : S_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // A new error outranks a simultaneous clear.
            if (err_now)        err_sticky <= 1'b1;
            else if (clear_err) err_sticky <= 1'b0;

            if (clear_err)
                err_count <= err_now ? ERR_CNT_W'(1) : '0;
            else if (err_now && err_count != CNT_MAX)
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gray_checker.sv
// Directed, table-driven bench for gray_checker; a second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_gray_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_err;
    logic [4:0] gray_in;

    logic [4:0] binary_out, binary_out_s;
    logic       valid, step, wrap, err, err_sticky;
    logic       valid_s, step_s, wrap_s, err_s, err_sticky_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    gray_checker u_dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .gray_in(gray_in), .binary_out(binary_out), .valid(valid),
        .step(step), .wrap(wrap), .err(err), .err_sticky(err_sticky),
        .err_count(err_count)
    );

    gray_checker #(.ERR_CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .gray_in(gray_in), .binary_out(binary_out_s), .valid(valid_s),
        .step(step_s), .wrap(wrap_s), .err(err_s), .err_sticky(err_sticky_s),
        .err_count(err_count_s)
    );

    typedef struct {
        logic [4:0] v;       // binary value whose Gray code is driven
        logic       clr;
        logic [4:0] bin;
        logic       vld;
        logic       stp;
        logic       wrp;
        logic       er;
        logic       sticky;
        logic [7:0] cnt;
        logic [1:0] cnt_s;
    } vec_t;

    localparam int NROWS = 71;
    vec_t tv[NROWS];

    int vseq[NROWS] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 0,
        1, 2, 3, 4,
        4, 4, 4, 4,
        5, 4, 2, 2, 4, 4, 4, 5, 5, 5,
        7, 7, 7, 9, 9, 9, 11, 11, 11, 13, 13, 13, 15, 15, 15,
        16, 16, 16, 16, 16
    };
    int err_rows[7] = '{44, 47, 53, 56, 59, 62, 65};

    function automatic logic [4:0] bin2gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input int row, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (row %0d): got %0d, expected %0d", name, row, act, exp);
    endtask

    initial begin
        int cnt, cnt_s, sticky;

        // Hand-derived expectations: outputs observed one edge after a row's
        // inputs show the value driven two rows earlier.
        for (int i = 0; i < NROWS; i++) begin
            tv[i].v   = 5'(vseq[i]);
            tv[i].clr = (i == 65 || i == 66);
            tv[i].bin = (i >= 2) ? 5'(vseq[i-2]) : 5'd0;
            tv[i].vld = (i != 0);
            tv[i].stp = (i >= 3 && i <= 38) || i == 43 || i == 50 || i == 68;
            tv[i].wrp = (i == 34);
            tv[i].er  = 1'b0;
        end
        foreach (err_rows[k]) begin
            tv[err_rows[k]].er    = 1'b1;
            tv[err_rows[k]].vld   = 1'b0;
            tv[err_rows[k]+1].vld = 1'b0;
        end
        cnt = 0; cnt_s = 0; sticky = 0;
        for (int i = 0; i < NROWS; i++) begin
            if (tv[i].clr) begin
                cnt    = tv[i].er ? 1 : 0;
                cnt_s  = cnt;
                sticky = tv[i].er ? 1 : 0;
            end else if (tv[i].er) begin
                if (cnt < 255) cnt++;
                if (cnt_s < 3) cnt_s++;
                sticky = 1;
            end
            tv[i].cnt    = 8'(cnt);
            tv[i].cnt_s  = 2'(cnt_s);
            tv[i].sticky = 1'(sticky);
        end

        reset = 1'b1; enable = 1'b0; clear_err = 1'b0; gray_in = 5'd0;
        @(negedge clk);
        chk("reset_binary", -1, binary_out, 0);
        chk("reset_valid",  -1, valid, 0);
        chk("reset_pulses", -1, {step, wrap, err, err_sticky}, 0);
        chk("reset_count",  -1, err_count, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NROWS; i++) begin
            enable    = 1'b1;
            clear_err = tv[i].clr;
            gray_in   = bin2gray(tv[i].v);
            @(negedge clk);
            chk("binary_out", i, binary_out, tv[i].bin);
            chk("valid",      i, valid, tv[i].vld);
            chk("step",       i, step, tv[i].stp);
            chk("wrap",       i, wrap, tv[i].wrp);
            chk("err",        i, err, tv[i].er);
            chk("err_sticky", i, err_sticky, tv[i].sticky);
            chk("err_count",  i, err_count, tv[i].cnt);
            chk("err_count_small", i, err_count_s, tv[i].cnt_s);
        end
        clear_err = 1'b0;

        // Jump 16 -> 20 to leave a non-zero count before the async reset.
        gray_in = bin2gray(20);
        repeat (5) @(negedge clk);
        chk("pre_reset_count",  100, err_count, 1);
        chk("pre_reset_sticky", 100, err_sticky, 1);

        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_binary", 101, binary_out, 0);
        chk("async_reset_valid",  101, valid, 0);
        chk("async_reset_count",  101, err_count, 0);
        chk("async_reset_sticky", 101, err_sticky, 0);
        chk("async_reset_err",    101, err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            gray_in = bin2gray(r);
            @(negedge clk);
            chk("restart_valid",  200 + r, valid, (r >= 1) ? 1 : 0);
            chk("restart_err",    200 + r, err, 0);
            chk("restart_binary", 200 + r, binary_out, (r >= 2) ? r - 2 : 0);
            chk("restart_step",   200 + r, step, (r >= 3) ? 1 : 0);
        end

        enable = 1'b0;
        @(negedge clk);
        chk("disable_valid", 300, valid, 0);
        chk("disable_step",  300, step, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
